// File: rtl/spill_buffer_pkg.sv
// rtl/spill_buffer_pkg.sv - shared helpers for the spill buffer
// Purpose: pointer-width helper used by the top and the pointer counter.
// Ports: none (package).
package spill_buffer_pkg;

  // A one-entry buffer still needs a 1-bit pointer so the index port exists.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spill_buffer_ptr.sv
// rtl/spill_buffer_ptr.sv - wrap-around pointer counter
// Purpose: counts 0..Depth-1 and wraps explicitly, so Depth need not be a power of two.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset, clears pointer
//   clr_i  - synchronous clear (flush), wins over inc_i
//   inc_i  - advance by one
//   ptr_o  - current pointer value
module spill_buffer_ptr
  import spill_buffer_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrWidth = ptr_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  logic [PtrWidth-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PtrWidth'(Depth - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/spill_buffer.sv
// rtl/spill_buffer.sv - parametrised elastic stream buffer with flush and occupancy
// Purpose: registered valid/ready stage of Depth entries; cuts every combinational
//          path except through flush_i (or everything when Bypass=1).
// Ports:
//   clk_i, rst_ni     - clock, synchronous active-low reset
//   flush_i           - drop all stored entries
//   valid_i, ready_o, data_i  - upstream channel
//   valid_o, ready_i, data_o  - downstream channel
//   usage_o           - number of occupied entries
module spill_buffer
  import spill_buffer_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 2,
  parameter bit          Bypass     = 1'b0,
  parameter int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DataWidth-1:0]  data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DataWidth-1:0]  data_o,
  output logic [UsageWidth-1:0] usage_o
);

  if (Depth < 1) begin : g_bad_depth
    $error("spill_buffer: Depth must be >= 1");
  end

  if (Bypass) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_ni, flush_i};

    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;
  end else begin : g_buffer
    localparam int unsigned PtrWidth = ptr_width(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]   rptr, wptr;
    logic [UsageWidth-1:0] cnt_q, cnt_d;
    logic                  push, pop;

    // Only registered state and flush_i reach the handshake outputs.
    assign valid_o = (cnt_q != '0) && !flush_i;
    assign ready_o = (cnt_q != UsageWidth'(Depth)) && !flush_i;
    assign data_o  = mem_q[rptr];
    assign usage_o = cnt_q;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
        cnt_d = '0;
      end else if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Flush leaves storage alone; only reset clears it.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= '0;
        end
      end else if (push) begin
        mem_q[wptr] <= data_i;
      end
    end

    spill_buffer_ptr #(.Depth(Depth)) u_rptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (pop),
      .ptr_o  (rptr)
    );

    spill_buffer_ptr #(.Depth(Depth)) u_wptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (push),
      .ptr_o  (wptr)
    );
  end

endmodule

// File: tb/tb_spill_buffer.sv
// tb/tb_spill_buffer.sv - self-checking bench for spill_buffer
module tb_spill_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // a: Depth=2, b: Depth=3, c: Depth=1, p: Bypass
  logic        a_flush, a_valid, a_ready_o, a_valid_o, a_ready;
  logic [15:0] a_data, a_data_o;
  logic [1:0]  a_usage;
  logic        b_flush, b_valid, b_ready_o, b_valid_o, b_ready;
  logic [15:0] b_data, b_data_o;
  logic [1:0]  b_usage;
  logic        c_flush, c_valid, c_ready_o, c_valid_o, c_ready;
  logic [15:0] c_data, c_data_o;
  logic [0:0]  c_usage;
  logic        p_flush, p_valid, p_ready_o, p_valid_o, p_ready;
  logic [15:0] p_data, p_data_o;
  logic [1:0]  p_usage;

  spill_buffer #(.DataWidth(16), .Depth(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .valid_i(a_valid), .ready_o(a_ready_o),
    .data_i(a_data), .valid_o(a_valid_o), .ready_i(a_ready), .data_o(a_data_o), .usage_o(a_usage));
  spill_buffer #(.DataWidth(16), .Depth(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .valid_i(b_valid), .ready_o(b_ready_o),
    .data_i(b_data), .valid_o(b_valid_o), .ready_i(b_ready), .data_o(b_data_o), .usage_o(b_usage));
  spill_buffer #(.DataWidth(16), .Depth(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .valid_i(c_valid), .ready_o(c_ready_o),
    .data_i(c_data), .valid_o(c_valid_o), .ready_i(c_ready), .data_o(c_data_o), .usage_o(c_usage));
  spill_buffer #(.DataWidth(16), .Depth(2), .Bypass(1'b1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(p_flush), .valid_i(p_valid), .ready_o(p_ready_o),
    .data_i(p_data), .valid_o(p_valid_o), .ready_i(p_ready), .data_o(p_data_o), .usage_o(p_usage));

  // Upstream must hold an un-accepted word (flush is the legal way to withdraw it).
  assert property (@(posedge clk) disable iff (!rst_n)
    (b_valid && !b_ready_o && !b_flush) |=> (b_valid && $stable(b_data)))
    else $error("FAIL upstream_hold: data_i changed while stalled");

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, r, f;
    logic [15:0] d;
    logic        ev, er;
    logic [15:0] ed;
    logic [1:0]  eu;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {valid_i, ready_i, flush_i, data_i | valid_o, ready_o, data_o, usage_o}, Depth=3
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b1, 16'h0000, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h000B, 1'b1, 1'b1, 16'h000A, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h000C, 1'b1, 1'b1, 16'h000A, 2'd2};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h000D, 1'b1, 1'b0, 16'h000A, 2'd3}; // full: pop only
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h000D, 1'b1, 1'b1, 16'h000B, 2'd2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000B, 2'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h000E, 1'b1, 1'b1, 16'h000C, 2'd2}; // push+pop
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b1, 16'h000D, 2'd2}; // wraps
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h0077, 1'b0, 1'b0, 16'h000E, 2'd2}; // flush
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000D, 2'd0}; // stale mem[0]
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0055, 1'b0, 1'b1, 16'h000D, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0055, 2'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000E, 2'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 16'h0088, 1'b0, 1'b0, 16'h000E, 2'd0}; // held flush
    tbl[14] = '{1'b1, 1'b0, 1'b1, 16'h0088, 1'b0, 1'b0, 16'h0055, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0055, 2'd0};

    {a_flush, a_valid, a_ready, a_data} = '0;
    {b_flush, b_valid, b_ready, b_data} = '0;
    {c_flush, c_valid, c_ready, c_data} = '0;
    {p_flush, p_valid, p_ready, p_data} = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_a_valid", a_valid_o, 0);  chk("rst_a_ready", a_ready_o, 1);
    chk("rst_a_data",  a_data_o, 0);   chk("rst_a_usage", a_usage, 0);
    chk("rst_b_valid", b_valid_o, 0);  chk("rst_b_ready", b_ready_o, 1);
    chk("rst_b_data",  b_data_o, 0);   chk("rst_b_usage", b_usage, 0);
    chk("rst_c_valid", c_valid_o, 0);  chk("rst_c_ready", c_ready_o, 1);
    @(negedge clk);

    // Table: fill, full, drain, wrap, flush, stale data, held flush.
    for (int i = 0; i < 16; i++) begin
      b_valid = tbl[i].v; b_ready = tbl[i].r; b_flush = tbl[i].f; b_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_valid", i), b_valid_o, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), b_ready_o, tbl[i].er);
      chk($sformatf("tbl%0d_data", i),  b_data_o,  tbl[i].ed);
      chk($sformatf("tbl%0d_usage", i), b_usage,   tbl[i].eu);
      @(negedge clk);
    end
    {b_flush, b_valid, b_ready, b_data} = '0;

    // Depth=2 streaming: one word per cycle, one cycle of latency.
    for (int k = 0; k < 18; k++) begin
      a_valid = (k < 16); a_data = 16'(k + 1); a_ready = 1'b1;
      #1;
      chk($sformatf("strm%0d_valid", k), a_valid_o, (k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) chk($sformatf("strm%0d_data", k), a_data_o, k);
      chk($sformatf("strm%0d_usage", k), a_usage, (k >= 1 && k <= 16) ? 1 : 0);
      chk($sformatf("strm%0d_ready", k), a_ready_o, 1);
      @(negedge clk);
    end
    {a_valid, a_ready} = '0;

    // Depth=1: alternate push/pop cycles.
    begin
      int pops = 0;
      c_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
        c_valid = 1'b1; c_data = 16'(100 + k / 2);
        #1;
        chk($sformatf("d1_%0d_ready", k), c_ready_o, (k % 2 == 0));
        chk($sformatf("d1_%0d_valid", k), c_valid_o, (k % 2 == 1));
        if (k % 2 == 1) chk($sformatf("d1_%0d_data", k), c_data_o, 100 + k / 2);
        if (c_valid_o && c_ready) pops++;
        @(negedge clk);
      end
      chk("d1_transfers", pops, 5);
      {c_valid, c_ready} = '0;
    end

    // Bypass: combinational pass-through, flush ignored.
    for (int k = 0; k < 3; k++) begin
      logic [15:0] d;
      d = 16'hBEEF ^ 16'(k * 16'h1111);
      p_valid = (k != 1); p_ready = (k != 2); p_flush = (k == 0); p_data = d;
      #1;
      chk($sformatf("byp%0d_valid", k), p_valid_o, (k != 1));
      chk($sformatf("byp%0d_ready", k), p_ready_o, (k != 2));
      chk($sformatf("byp%0d_data", k),  p_data_o, d);
      chk($sformatf("byp%0d_usage", k), p_usage, 0);
    end
    @(negedge clk);

    // Random valid/ready on Depth=3 against a queue model.
    begin
      logic [15:0] q[$];
      logic [15:0] nxt = 16'h0100;
      logic        hold = 1'b0;
      logic        push_m, pop_m;
      int pushes = 0, pops = 0, cyc = 0;
      while (pops < 1000 && cyc < 20000) begin
        if (!hold) begin
          b_valid = ($urandom_range(0, 3) != 0);
          b_data  = nxt;
        end
        b_ready = ($urandom_range(0, 3) != 0);
        #1;
        chk("rnd_usage", b_usage, pushes - pops);
        chk("rnd_valid", b_valid_o, q.size() != 0);
        chk("rnd_ready", b_ready_o, q.size() != 3);
        if (q.size() != 0) chk("rnd_data", b_data_o, q[0]);
        b_ready = ~b_ready;
        #1;
        chk("rnd_ready_vs_ready_i", b_ready_o, q.size() != 3);
        b_ready = ~b_ready;
        #1;
        push_m = b_valid && (q.size() != 3);
        pop_m  = (q.size() != 0) && b_ready;
        if (pop_m) begin
          void'(q.pop_front());
          pops++;
        end
        if (push_m) begin
          q.push_back(b_data);
          nxt = nxt + 16'd1;
          pushes++;
        end
        hold = b_valid && !push_m;
        @(negedge clk);
        cyc++;
      end
      chk("rnd_completed", pops >= 1000, 1);
    end

    // Drain, refill to two, then reset mid-operation.
    b_valid = 1'b0; b_ready = 1'b1;
    repeat (4) @(negedge clk);
    b_ready = 1'b0;
    b_valid = 1'b1; b_data = 16'h0011;
    @(negedge clk);
    b_data = 16'h0022;
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("mid_usage_before", b_usage, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_usage_after", b_usage, 0);
    chk("mid_valid_after", b_valid_o, 0);
    chk("mid_ready_after", b_ready_o, 1);
    chk("mid_data_after",  b_data_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
